rr_mux_reg: RTL and testbench

Parametrised N-channel, WIDTH-bit registered multiplexer with valid/ready handshakes. It supersedes the plain 2:1 combinational operand mux in the processor datapath. Channel choice is either round-robin arbitration or an explicit select, and the result is held in a one-entry output register. It sits between multiple operand/result producers and a single consumer, such as the ALU input stage or the writeback path.

---
 rtl/rr_mux_reg.sv | 131 +++++++++++++
 tb/tb_rr_mux_reg.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_reg.sv
// rr_mux_reg: N-channel registered multiplexer with valid/ready handshakes.
// A channel is picked either by round-robin arbitration (mode = 0) or by an
// explicit select (mode = 1). The winner's data lands in a one-entry output
// register. in_ready is the only combinational output. It is derived from
// the handshake and select inputs and never from in_data.
module rr_mux_reg #(
    parameter  int WIDTH = 64,
    parameter  int N     = 4,
    localparam int SELW  = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mode,
    input  logic [SELW-1:0]      select,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_src,
    input  logic                 out_ready
);

    localparam int PADN = 2 ** SELW;

    logic [SELW-1:0]  ptr_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_data_r;
    logic [SELW-1:0]  out_src_r;

    logic             load_en_s;
    logic [PADN-1:0]  valid_pad_s;
    logic             grant_valid_s;
    logic [SELW-1:0]  grant_s;
    logic [SELW-1:0]  ptr_next_s;
    logic [N-1:0]     in_ready_s;
    logic [WIDTH-1:0] grant_data_s;
    logic             transfer_s;

    // The output register can accept new data when it is empty or is being drained.
    assign load_en_s = !out_valid_r || out_ready;

    // Widen in_valid to the full select range so out-of-range selects read as invalid.
    always_comb begin
        valid_pad_s         = '0;
        valid_pad_s[N-1:0]  = in_valid;
    end

    // Grant selection: rotating priority from ptr_r, or explicit select.
    always_comb begin
        int sum;
        int idx;
        logic hit;
        grant_valid_s = 1'b0;
        grant_s       = '0;
        sum           = 0;
        idx           = 0;
        hit           = 1'b0;
        if (mode == 1'b0) begin
            // Earliest channel after the pointer wins; later hits are ignored.
            for (int i = 0; i < N; i++) begin
                sum           = int'(ptr_r) + i;
                idx           = (sum >= N) ? (sum - N) : sum;
                hit           = in_valid[idx] & ~grant_valid_s;
                grant_s       = hit ? SELW'(idx) : grant_s;
                grant_valid_s = grant_valid_s | hit;
            end
        end else begin
            // An out-of-range select lands on a zero pad bit and never grants.
            if ((int'(select) < N) && valid_pad_s[select]) begin
                grant_valid_s = 1'b1;
                grant_s       = select;
            end else begin
                grant_valid_s = 1'b0;
                grant_s       = '0;
            end
        end
    end

    // Next round-robin pointer: one past the winner, wrapping at N rather than 2**SELW.
    always_comb begin
        if (grant_s == SELW'(N - 1)) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = grant_s + SELW'(1);
        end
    end

    // One-hot ready toward the granted producer, only when the register can load.
    always_comb begin
        in_ready_s = '0;
        if (load_en_s && grant_valid_s) begin
            in_ready_s[grant_s] = 1'b1;
        end else begin
            in_ready_s = '0;
        end
    end

    assign transfer_s   = load_en_s && grant_valid_s;
    assign grant_data_s = in_data[int'(grant_s)*WIDTH +: WIDTH];

    // Output register and arbitration pointer; reset overrides any transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_src_r   <= '0;
            ptr_r       <= '0;
        end else if (transfer_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= grant_data_s;
            out_src_r   <= grant_s;
            if (mode == 1'b0) begin
                ptr_r <= ptr_next_s;
            end else begin
                ptr_r <= ptr_r;
            end
        end else if (out_valid_r && out_ready) begin
            // Drained with nothing to replace it: keep data/src, drop valid.
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_src   = out_src_r;

endmodule

// File: tb/tb_rr_mux_reg.sv
// Directed testbench for rr_mux_reg (N = 4, WIDTH = 64). The stimulus process
// queues the hand-computed outputs. A negedge monitor pops and compares one
// entry each time the consumer accepts an output. Register state and in_ready
// are checked inline.
module tb_rr_mux_reg;

    localparam int WIDTH = 64;
    localparam int N     = 4;
    localparam int SELW  = 2;

    logic                 clk;
    logic                 reset;
    logic                 mode;
    logic [SELW-1:0]      select;
    logic [N-1:0]         in_valid;
    logic [N*WIDTH-1:0]   in_data;
    logic [N-1:0]         in_ready;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_src;
    logic                 out_ready;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SELW-1:0]  src;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    rr_mux_reg #(.WIDTH(WIDTH), .N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .select    (select),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    // 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input logic [WIDTH-1:0] d, input logic [SELW-1:0] s);
        exp_t e;
        e.data = d;
        e.src  = s;
        sb_q.push_back(e);
    endtask

    task automatic set_data(input logic [63:0] d0, input logic [63:0] d1,
                            input logic [63:0] d2, input logic [63:0] d3);
        in_data = {d3, d2, d1, d0};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted output must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_output", {62'd0, out_src}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                check("sb_data", out_data, e.data);
                check("sb_src", {62'd0, out_src}, {62'd0, e.src});
            end
        end
    end

    logic [N-1:0] rr_rdy_exp [4];

    initial begin
        rr_rdy_exp = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
        reset     = 1'b1;
        mode      = 1'b0;
        select    = 2'd0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        set_data(64'd10, 64'd20, 64'd30, 64'd40);

        // Reset held for two edges with every channel valid.
        for (int i = 0; i < 2; i++) begin
            step();
            @(negedge clk);
            check("rst_out_valid", {63'd0, out_valid}, 64'd0);
            check("rst_out_data", out_data, 64'd0);
            check("rst_out_src", {62'd0, out_src}, 64'd0);
        end
        step();

        // Round-robin fairness: all valid, 8 transfers starting at channel 0.
        reset = 1'b0;
        for (int r = 0; r < 2; r++) begin
            push(64'd10, 2'd0);
            push(64'd20, 2'd1);
            push(64'd30, 2'd2);
            push(64'd40, 2'd3);
        end
        repeat (8) step();

        // Skip and wrap: only channels 1 and 3 valid.
        in_valid = 4'b1010;
        push(64'd20, 2'd1);
        push(64'd40, 2'd3);
        push(64'd20, 2'd1);
        push(64'd40, 2'd3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("skip_in_ready", {60'd0, in_ready}, {60'd0, rr_rdy_exp[i]});
            step();
        end

        // Fixed select of channel 2 with all channels valid.
        mode     = 1'b1;
        select   = 2'd2;
        in_valid = 4'b1111;
        set_data(64'd12, 64'd20, 64'd15, 64'd40);
        push(64'd15, 2'd2);
        push(64'd15, 2'd2);
        push(64'd15, 2'd2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("fixed_in_ready", {60'd0, in_ready}, 64'd4);
            step();
        end
        select = 2'd0;
        push(64'd12, 2'd0);
        step();

        // Load 15 from channel 2, then hold it under backpressure.
        select = 2'd2;
        push(64'd15, 2'd2);
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", {63'd0, out_valid}, 64'd1);
            check("bp_out_data", out_data, 64'd15);
            check("bp_out_src", {62'd0, out_src}, 64'd2);
            check("bp_in_ready", {60'd0, in_ready}, 64'd0);
            step();
        end

        // Release: the held 15 drains while channel 0 loads in the same cycle.
        out_ready = 1'b1;
        mode      = 1'b0;
        @(negedge clk);
        check("release_in_ready", {60'd0, in_ready}, 64'd1);
        step();

        // Reset while a loaded output is held; the held entry is discarded.
        reset     = 1'b1;
        out_ready = 1'b0;
        step();
        @(negedge clk);
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_out_data", out_data, 64'd0);
        check("midrst_out_src", {62'd0, out_src}, 64'd0);
        check("midrst_in_ready", {60'd0, in_ready}, 64'd1);
        step();

        // The pointer was 1 before reset; the first grant must now be channel 0.
        reset     = 1'b0;
        out_ready = 1'b1;
        push(64'd12, 2'd0);
        step();

        // No grant: the output drains and the last data is retained.
        in_valid = 4'b0000;
        step();
        @(negedge clk);
        check("nogrant_out_valid", {63'd0, out_valid}, 64'd0);
        check("nogrant_out_data", out_data, 64'd12);
        check("nogrant_out_src", {62'd0, out_src}, 64'd0);
        check("nogrant_in_ready", {60'd0, in_ready}, 64'd0);
        step();
        step();

        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
